// File: rtl/mem_pkg.sv
// ---------------------------------------------------------------------------
// mem_pkg : shared FSM/op encodings and default widths for mem_responder
// Rev 1.0 : initial release
// ---------------------------------------------------------------------------
`default_nettype none

package mem_pkg;

  localparam int ADDR_W_DEF = 16;
  localparam int DATA_W_DEF = 16;
  localparam int CNT_W      = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    RD_DONE = 2'd2,
    WR_DONE = 2'd3
  } state_e;

  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } op_e;

endpackage

`default_nettype wire

// File: rtl/mem_responder_if.sv
// ---------------------------------------------------------------------------
// mem_responder_if : controller-to-memory strobe bus (MEM_PARITY_EN adds inj_par)
// Rev 1.0 : initial release
// ---------------------------------------------------------------------------
`default_nettype none

interface mem_responder_if import mem_pkg::*; #(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);

  logic              memrd;
  logic              memwr;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              rdata_valid;
  logic              wr_done;
  logic              busy;
  logic              err;
`ifdef MEM_PARITY_EN
  logic              inj_par;
`endif

  modport master (
    output memrd, memwr, addr, wdata,
`ifdef MEM_PARITY_EN
    output inj_par,
`endif
    input  rdata, rdata_valid, wr_done, busy, err
  );

  modport slave (
    input  memrd, memwr, addr, wdata,
`ifdef MEM_PARITY_EN
    input  inj_par,
`endif
    output rdata, rdata_valid, wr_done, busy, err
  );

endinterface

`default_nettype wire

// File: rtl/mem_array.sv
// ---------------------------------------------------------------------------
// mem_array : synchronous single-port RAM, read-first, registered output
// Rev 1.0 : initial release
// ---------------------------------------------------------------------------
`default_nettype none

module mem_array #(
  parameter int DEPTH = 256,
  parameter int WIDTH = 16,
  parameter int AW    = 8
) (
  input  wire logic             clk,
  input  wire logic             we,
  input  wire logic [AW-1:0]    addr,
  input  wire logic [WIDTH-1:0] din,
  output logic      [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] dout_q;

  // Contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[addr] <= din;
    end
    dout_q <= mem_q[addr];
  end

  assign dout = dout_q;

endmodule

`default_nettype wire

// File: rtl/mem_responder.sv
// ---------------------------------------------------------------------------
// mem_responder : wait-stated RAM responder for memrd/memwr strobes
// Optional feature macro: MEM_PARITY_EN (even parity per word + inj_par)
// Rev 1.0 : initial release
// ---------------------------------------------------------------------------
`default_nettype none

module mem_responder import mem_pkg::*; #(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 1
) (
  input  wire logic       clk,
  input  wire logic       rst_n,
  mem_responder_if.slave  bus
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
`ifdef MEM_PARITY_EN
  localparam int PAR_W = 1;
`else
  localparam int PAR_W = 0;
`endif
  localparam int              WORD_W    = DATA_W + PAR_W;
  localparam logic [CNT_W-1:0] WAIT_LOAD =
    (WAIT_CYCLES > 0) ? CNT_W'(WAIT_CYCLES - 1) : '0;

  if ((WAIT_CYCLES > 15) || (WAIT_CYCLES < 0)) begin : g_wait_range_err
    $error("mem_responder: WAIT_CYCLES must be within 0..15");
  end

  state_e            state_q, state_d;
  op_e               op_q, op_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              rdata_valid_q, rdata_valid_d;
  logic              wr_done_q, wr_done_d;
  logic              busy_q, busy_d;
  logic              err_q, err_d;

  logic              ram_we;
  logic [AW-1:0]     ram_addr;
  logic [WORD_W-1:0] ram_din;
  logic [WORD_W-1:0] ram_dout;

  logic [ADDR_W-1:0] addr_in;
  logic              in_range;

  assign addr_in  = bus.addr;
  assign in_range = (32'(addr_in) < 32'(DEPTH));

`ifdef MEM_PARITY_EN
  assign ram_din = {(^wdata_q) ^ bus.inj_par, wdata_q};
`else
  assign ram_din = wdata_q;
`endif

  always_comb begin
    state_d       = state_q;
    op_d          = op_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    cnt_d         = cnt_q;
    rdata_d       = rdata_q;
    rdata_valid_d = 1'b0;
    wr_done_d     = 1'b0;
    err_d         = 1'b0;
    ram_we        = 1'b0;
    ram_addr      = addr_q;

    case (state_q)
      IDLE: begin
        // Present the live address so the RAM output is ready even with zero wait states.
        ram_addr = addr_in[AW-1:0];
        if (bus.memrd && bus.memwr) begin
          err_d = 1'b1;
        end else if (bus.memrd || bus.memwr) begin
          if (!in_range) begin
            err_d = 1'b1;
          end else begin
            op_d    = bus.memrd ? OP_RD : OP_WR;
            addr_d  = addr_in[AW-1:0];
            wdata_d = bus.wdata;
            if (WAIT_CYCLES == 0) begin
              state_d = bus.memrd ? RD_DONE : WR_DONE;
            end else begin
              state_d = WAIT;
              cnt_d   = WAIT_LOAD;
            end
          end
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          state_d = (op_q == OP_RD) ? RD_DONE : WR_DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RD_DONE: begin
        rdata_d       = ram_dout[DATA_W-1:0];
        rdata_valid_d = 1'b1;
`ifdef MEM_PARITY_EN
        err_d         = ^ram_dout;
`endif
        state_d       = IDLE;
      end
      WR_DONE: begin
        ram_we    = 1'b1;
        wr_done_d = 1'b1;
        state_d   = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      op_q          <= OP_RD;
      addr_q        <= '0;
      wdata_q       <= '0;
      rdata_q       <= '0;
      cnt_q         <= '0;
      rdata_valid_q <= 1'b0;
      wr_done_q     <= 1'b0;
      busy_q        <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      op_q          <= op_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      rdata_q       <= rdata_d;
      cnt_q         <= cnt_d;
      rdata_valid_q <= rdata_valid_d;
      wr_done_q     <= wr_done_d;
      busy_q        <= busy_d;
      err_q         <= err_d;
    end
  end

  mem_array #(
    .DEPTH (DEPTH),
    .WIDTH (WORD_W),
    .AW    (AW)
  ) u_mem_array (
    .clk  (clk),
    .we   (ram_we),
    .addr (ram_addr),
    .din  (ram_din),
    .dout (ram_dout)
  );

  assign bus.rdata       = rdata_q;
  assign bus.rdata_valid = rdata_valid_q;
  assign bus.wr_done     = wr_done_q;
  assign bus.busy        = busy_q;
  assign bus.err         = err_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_responder.sv
// ---------------------------------------------------------------------------
// tb_mem_responder : scoreboard bench, dut0 WAIT_CYCLES=1, dut1 WAIT_CYCLES=3
// Rev 1.0 : initial release
// ---------------------------------------------------------------------------
`default_nettype none

module tb_mem_responder;

  typedef struct packed {
    logic        rv;
    logic        wd;
    logic        er;
    logic [15:0] data;
    logic [31:0] cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst0_n;
  logic        rst1_n;
  logic [31:0] cyc = 0;
  int          checks = 0;
  int          errors = 0;
  exp_t        q0[$];
  exp_t        q1[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_responder_if #(.ADDR_W(16), .DATA_W(16)) bus0 ();
  mem_responder_if #(.ADDR_W(16), .DATA_W(16)) bus1 ();

  mem_responder #(.ADDR_W(16), .DATA_W(16), .DEPTH(256), .WAIT_CYCLES(1)) dut0 (
    .clk(clk), .rst_n(rst0_n), .bus(bus0));
  mem_responder #(.ADDR_W(16), .DATA_W(16), .DEPTH(256), .WAIT_CYCLES(3)) dut1 (
    .clk(clk), .rst_n(rst1_n), .bus(bus1));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic drive(input int k, input logic rd, input logic wr,
                       input logic [15:0] a, input logic [15:0] d);
    if (k == 0) begin
      bus0.memrd = rd; bus0.memwr = wr; bus0.addr = a; bus0.wdata = d;
    end else begin
      bus1.memrd = rd; bus1.memwr = wr; bus1.addr = a; bus1.wdata = d;
    end
  endtask

  task automatic push(input int k, input logic rv, input logic wd, input logic er,
                      input logic [15:0] data, input logic [31:0] c);
    exp_t e;
    e = '{rv: rv, wd: wd, er: er, data: data, cyc: c};
    if (k == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  function automatic int pend(input int k);
    return (k == 0) ? q0.size() : q1.size();
  endfunction

  function automatic int busy_of(input int k);
    return (k == 0) ? int'(bus0.busy) : int'(bus1.busy);
  endfunction

  function automatic int lat_of(input int k);
    return (k == 0) ? 2 : 4;
  endfunction

  task automatic drain(input int k, input string name);
    for (int i = 0; i < 20 && pend(k) != 0; i++) @(negedge clk);
    chk({name, "_pending"}, pend(k), 0);
  endtask

  // One request; expected event pushed, busy run counted, then the queue must drain.
  task automatic txn(input int k, input logic rd, input logic wr,
                     input logic [15:0] a, input logic [15:0] d,
                     input logic rv, input logic wd, input logic er,
                     input logic [15:0] exp_d, input int lat, input int exp_busy,
                     input string name);
    int nb;
    @(negedge clk);
    drive(k, rd, wr, a, d);
    push(k, rv, wd, er, exp_d, cyc + 1 + lat);
    nb = 0;
    for (int i = 1; i <= lat + 2; i++) begin
      @(negedge clk);
      if (i == 1) drive(k, 1'b0, 1'b0, a, d);
      nb += busy_of(k);
    end
    chk({name, "_busy"}, nb, exp_busy);
    drain(k, name);
  endtask

  task automatic wr(input int k, input logic [15:0] a, input logic [15:0] d, input string name);
    txn(k, 1'b0, 1'b1, a, d, 1'b0, 1'b1, 1'b0, 16'h0, lat_of(k), lat_of(k), name);
  endtask

  task automatic rd(input int k, input logic [15:0] a, input logic [15:0] exp, input string name);
    txn(k, 1'b1, 1'b0, a, 16'h0, 1'b1, 1'b0, 1'b0, exp, lat_of(k), lat_of(k), name);
  endtask

  task automatic bad(input int k, input logic r, input logic w, input logic [15:0] a,
                     input string name);
    txn(k, r, w, a, 16'h1111, 1'b0, 1'b0, 1'b1, 16'h0, 0, 0, name);
  endtask

  task automatic mon(input int k);
    logic        rv, wd, er, rstn;
    logic [15:0] rdat;
    exp_t        e;
    rstn = (k == 0) ? rst0_n : rst1_n;
    rv   = (k == 0) ? bus0.rdata_valid : bus1.rdata_valid;
    wd   = (k == 0) ? bus0.wr_done     : bus1.wr_done;
    er   = (k == 0) ? bus0.err         : bus1.err;
    rdat = (k == 0) ? bus0.rdata       : bus1.rdata;
    if (rstn && (rv || wd || er)) begin
      if (pend(k) == 0) begin
        chk($sformatf("dut%0d_unexpected_evt", k), {29'd0, rv, wd, er}, 32'd0);
      end else begin
        e = (k == 0) ? q0.pop_front() : q1.pop_front();
        chk($sformatf("dut%0d_evt_flags", k), {29'd0, rv, wd, er}, {29'd0, e.rv, e.wd, e.er});
        chk($sformatf("dut%0d_evt_cycle", k), cyc, e.cyc);
        if (e.rv) chk($sformatf("dut%0d_evt_rdata", k), {16'd0, rdat}, {16'd0, e.data});
      end
    end
  endtask

  always @(negedge clk) begin
    mon(0);
    mon(1);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] n0;
    rst0_n = 1'b0;
    rst1_n = 1'b0;
    drive(0, 1'b0, 1'b0, 16'h0, 16'h0);
    drive(1, 1'b0, 1'b0, 16'h0, 16'h0);
`ifdef MEM_PARITY_EN
    bus0.inj_par = 1'b0;
    bus1.inj_par = 1'b0;
`endif
    repeat (3) @(negedge clk);
    chk("reset_dut0", {bus0.rdata, 12'd0, bus0.rdata_valid, bus0.wr_done, bus0.busy, bus0.err}, 32'd0);
    chk("reset_dut1", {bus1.rdata, 12'd0, bus1.rdata_valid, bus1.wr_done, bus1.busy, bus1.err}, 32'd0);
    rst0_n = 1'b1;
    rst1_n = 1'b1;

    wr(0, 16'h0010, 16'hBEEF, "wr_beef");
    rd(0, 16'h0010, 16'hBEEF, "rd_beef");

    wr(0, 16'h0004, 16'h5A5A, "wr_5a5a");
    bad(0, 1'b1, 1'b1, 16'h0004, "rdwr_both");
    rd(0, 16'h0004, 16'h5A5A, "rd_after_both");

    bad(0, 1'b1, 1'b0, 16'h0100, "rd_oor");
    chk("rd_oor_rdata_hold", {16'd0, bus0.rdata}, 32'h5A5A);
    bad(0, 1'b0, 1'b1, 16'h0100, "wr_oor");

    wr(0, 16'h00FF, 16'h7E57, "wr_last");
    rd(0, 16'h00FF, 16'h7E57, "rd_last");

    // Requests while busy are ignored; latched wdata wins.
    @(negedge clk);
    drive(0, 1'b0, 1'b1, 16'h0020, 16'h1234);
    push(0, 1'b0, 1'b1, 1'b0, 16'h0, cyc + 3);
    @(negedge clk);
    drive(0, 1'b1, 1'b0, 16'h0030, 16'hFFFF);
    @(negedge clk);
    @(negedge clk);
    drive(0, 1'b0, 1'b0, 16'h0030, 16'hFFFF);
    repeat (3) @(negedge clk);
    drain(0, "wr_busy_ignore");
    rd(0, 16'h0020, 16'h1234, "rd_busy_ignore");

    // Back-to-back: read issued in the first IDLE cycle after WR_DONE.
    @(negedge clk);
    n0 = cyc;
    drive(0, 1'b0, 1'b1, 16'h0040, 16'hC0DE);
    push(0, 1'b0, 1'b1, 1'b0, 16'h0, n0 + 3);
    @(negedge clk);
    drive(0, 1'b0, 1'b0, 16'h0040, 16'h0);
    @(negedge clk);
    @(negedge clk);
    drive(0, 1'b1, 1'b0, 16'h0040, 16'h0);
    push(0, 1'b1, 1'b0, 1'b0, 16'hC0DE, n0 + 6);
    @(negedge clk);
    drive(0, 1'b0, 1'b0, 16'h0040, 16'h0);
    drain(0, "back_to_back");

`ifdef MEM_PARITY_EN
    bus0.inj_par = 1'b1;
    wr(0, 16'h0007, 16'h0001, "wr_par_inj");
    bus0.inj_par = 1'b0;
    txn(0, 1'b1, 1'b0, 16'h0007, 16'h0, 1'b1, 1'b0, 1'b1, 16'h0001, 2, 2, "rd_par_err");
    rd(0, 16'h0010, 16'hBEEF, "rd_par_ok");
`endif

    // WAIT_CYCLES=3: reset during the second WAIT cycle abandons the write.
    wr(1, 16'h0005, 16'h5555, "w3_wr_old");
    rd(1, 16'h0005, 16'h5555, "w3_rd_old");
    @(negedge clk);
    drive(1, 1'b0, 1'b1, 16'h0005, 16'hAAAA);
    @(negedge clk);
    drive(1, 1'b0, 1'b0, 16'h0005, 16'hAAAA);
    chk("w3_busy_in_wait", {31'd0, bus1.busy}, 32'd1);
    @(negedge clk);
    rst1_n = 1'b0;
    #1;
    chk("w3_rst_outputs", {bus1.rdata, 12'd0, bus1.rdata_valid, bus1.wr_done, bus1.busy, bus1.err}, 32'd0);
    repeat (2) @(negedge clk);
    rst1_n = 1'b1;
    repeat (6) @(negedge clk);
    rd(1, 16'h0005, 16'h5555, "w3_rd_after_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
